// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect controls from the pipeline, the instruction memory
// handshake and the fetched-instruction outputs.
interface fetch_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            stall;
    logic            branch_en;
    logic            jalr_en;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pc_out;
    logic            misalign_trap;

    // master = the fetch unit, slave = memory plus downstream pipeline
    modport master (
        input  stall, branch_en, jalr_en, imm, rs1, flush, flush_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instruction, pc_out, misalign_trap
    );
    modport slave (
        output stall, branch_en, jalr_en, imm, rs1, flush, flush_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instruction, pc_out, misalign_trap
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with branch/jalr redirect,
// misalignment trap and flush handling.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding at pc, waiting for imem_ack
// VALID | instruction held for downstream, consumed when stall=0
// DROP  | flushed while a request was in flight, absorbing its ack
// TRAP  | redirect target misaligned, waits for flush
module fetch_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              ILEN         = 32
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, VALID, DROP, TRAP} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_out_q;
    logic [ILEN-1:0] instr_q;
    logic            req_q;
    logic            valid_q;
    logic            trap_q;

    always_comb begin
        target = pc + XLEN'(4);
        if (bus.jalr_en)
            target = (bus.rs1 + bus.imm) & ~XLEN'(1);
        else if (bus.branch_en)
            target = pc + (bus.imm << 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            pc_out_q <= RESET_VECTOR;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        pc     <= bus.flush_pc;
                        trap_q <= 1'b0;
                    end
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.flush) begin
                        pc     <= bus.flush_pc;
                        trap_q <= 1'b0;
                        // an ack in the same cycle closes the old request, so refetch at once
                        if (bus.imem_ack) begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end else begin
                            state <= DROP;
                            req_q <= 1'b0;
                        end
                    end else if (bus.imem_ack) begin
                        instr_q  <= bus.imem_rdata;
                        pc_out_q <= pc;
                        state    <= VALID;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                VALID: begin
                    if (bus.flush) begin
                        pc      <= bus.flush_pc;
                        trap_q  <= 1'b0;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        valid_q <= 1'b0;
                        if (target[1:0] != 2'b00) begin
                            trap_q <= 1'b1;
                            state  <= TRAP;
                        end else begin
                            pc    <= target;
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (bus.flush) begin
                        pc     <= bus.flush_pc;
                        trap_q <= 1'b0;
                    end
                    // the abandoned request has completed; nothing is in flight any more
                    if (bus.imem_ack) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                end
                TRAP: begin
                    if (bus.flush) begin
                        pc     <= bus.flush_pc;
                        trap_q <= 1'b0;
                        state  <= FETCH;
                        req_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req      = req_q;
    assign bus.imem_addr     = pc;
    assign bus.instr_valid   = valid_q;
    assign bus.instruction   = instr_q;
    assign bus.pc_out        = pc_out_q;
    assign bus.misalign_trap = trap_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: redirect vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_fetch_unit;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_VALID = 2;
    localparam int M_DROP  = 3;
    localparam int M_TRAP  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(64'h0), .ILEN(ILEN)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // memory responder: auto mode answers each request after mem_lat cycles
    bit          mem_auto;
    int          mem_lat;
    bit          busy;
    int          cnt;
    logic [63:0] maddr;
    logic        auto_ack;
    logic [31:0] auto_rdata;
    logic        man_ack;
    logic [31:0] man_rdata;

    assign bus.imem_ack   = mem_auto ? auto_ack : man_ack;
    assign bus.imem_rdata = mem_auto ? auto_rdata : man_rdata;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    always @(negedge clk) begin
        auto_ack = 1'b0;
        if (reset || !mem_auto) begin
            busy = 1'b0;
        end else begin
            if (!busy && bus.imem_req) begin
                busy  = 1'b1;
                maddr = bus.imem_addr;
                cnt   = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            end
            if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    auto_ack   = 1'b1;
                    auto_rdata = memfn(maddr);
                    busy       = 1'b0;
                end
            end
        end
    end

    // behavioural reference
    int          m_ph;
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_trap;

    task automatic model_reset();
        m_ph = M_IDLE; m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0; m_trap = 1'b0;
    endtask

    task automatic model_step();
        logic [63:0] t;
        if (bus.flush) begin
            m_pc   = bus.flush_pc;
            m_trap = 1'b0;
            if (m_ph == M_FETCH)      m_ph = bus.imem_ack ? M_FETCH : M_DROP;
            else if (m_ph == M_DROP)  m_ph = bus.imem_ack ? M_FETCH : M_DROP;
            else                      m_ph = M_FETCH;
        end else begin
            case (m_ph)
                M_IDLE: m_ph = M_FETCH;
                M_FETCH: if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata;
                    m_ipc   = m_pc;
                    m_ph    = M_VALID;
                end
                M_VALID: if (!bus.stall) begin
                    if (bus.jalr_en)        t = (bus.rs1 + bus.imm) & ~64'h1;
                    else if (bus.branch_en) t = m_pc + bus.imm * 2;
                    else                    t = m_pc + 64'd4;
                    if (t % 4 != 0) begin
                        m_trap = 1'b1;
                        m_ph   = M_TRAP;
                    end else begin
                        m_pc = t;
                        m_ph = M_FETCH;
                    end
                end
                M_DROP: if (bus.imem_ack) m_ph = M_FETCH;
                default: ;
            endcase
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk1("req", bus.imem_req, m_ph == M_FETCH);
        chk64("addr", bus.imem_addr, m_pc);
        chk1("valid", bus.instr_valid, m_ph == M_VALID);
        chk1("trap", bus.misalign_trap, m_trap);
        chk64("instruction", 64'(bus.instruction), 64'(m_instr));
        chk64("pc_out", bus.pc_out, m_ipc);
    endtask

    task automatic cycle();
        @(negedge clk); #1;
        model_step();
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.branch_en = 1'b0; bus.jalr_en = 1'b0;
        bus.imm = 64'h0; bus.rs1 = 64'h0; bus.flush = 1'b0; bus.flush_pc = 64'h0;
    endtask

    // reset asserted mid-cycle: outputs must drop before any clock edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [63:0] pc0;
        logic        br;
        logic        jalr;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] exp_addr;
        logic        exp_trap;
    } vec_t;

    vec_t        tbl [9];
    logic [63:0] addrs[$];
    logic [31:0] held;

    initial begin
        tbl[0] = '{pc0:64'h100, br:1'b1, jalr:1'b0, imm:64'h10, rs1:64'h0, exp_addr:64'h120, exp_trap:1'b0};
        tbl[1] = '{pc0:64'h100, br:1'b1, jalr:1'b1, imm:64'h4, rs1:64'h201, exp_addr:64'h204, exp_trap:1'b0};
        tbl[2] = '{pc0:64'h100, br:1'b0, jalr:1'b1, imm:64'h2, rs1:64'h200, exp_addr:64'h100, exp_trap:1'b1};
        tbl[3] = '{pc0:64'h100, br:1'b0, jalr:1'b0, imm:64'h7, rs1:64'h3, exp_addr:64'h104, exp_trap:1'b0};
        tbl[4] = '{pc0:64'h100, br:1'b1, jalr:1'b0, imm:64'hFFFF_FFFF_FFFF_FFF8, rs1:64'h0, exp_addr:64'hF0, exp_trap:1'b0};
        tbl[5] = '{pc0:64'h100, br:1'b1, jalr:1'b0, imm:64'h1, rs1:64'h0, exp_addr:64'h100, exp_trap:1'b1};
        tbl[6] = '{pc0:64'h0, br:1'b1, jalr:1'b0, imm:64'hFFFF_FFFF_FFFF_FFFE, rs1:64'h0, exp_addr:64'hFFFF_FFFF_FFFF_FFFC, exp_trap:1'b0};
        tbl[7] = '{pc0:64'hFFFF_FFFF_FFFF_FFFC, br:1'b0, jalr:1'b0, imm:64'h0, rs1:64'h0, exp_addr:64'h0, exp_trap:1'b0};
        tbl[8] = '{pc0:64'h100, br:1'b0, jalr:1'b1, imm:64'h0, rs1:64'h1001, exp_addr:64'h1000, exp_trap:1'b0};

        reset = 1'b1;
        idle_inputs();
        mem_auto = 1'b1; mem_lat = 1; man_ack = 1'b0; man_rdata = 32'h0;
        @(posedge clk); #1;

        // sequential fetch, ack one cycle after each request
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (bus.imem_req) addrs.push_back(bus.imem_addr);
            chk1("seq_valid", bus.instr_valid, (k % 2) == 0);
        end
        chk64("seq_count", 64'(addrs.size()), 64'd4);
        for (int j = 0; j < addrs.size(); j++) chk64("seq_addr", addrs[j], 64'(j * 4));

        // stall holds the instruction at pc 12
        held = memfn(64'd12);
        bus.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk64("stall_instr", 64'(bus.instruction), 64'(held));
            chk64("stall_pc", bus.pc_out, 64'd12);
            chk1("stall_req", bus.imem_req, 1'b0);
        end
        bus.stall = 1'b0;
        cycle();
        chk64("stall_release_addr", bus.imem_addr, 64'd16);

        // redirect vector table
        for (int t = 0; t < 9; t++) begin
            idle_inputs();
            mem_auto = 1'b1; mem_lat = 1;
            do_reset();
            bus.flush = 1'b1; bus.flush_pc = tbl[t].pc0;
            cycle();
            bus.flush = 1'b0;
            cycle();
            chk64("tbl_pc_out", bus.pc_out, tbl[t].pc0);
            bus.branch_en = tbl[t].br; bus.jalr_en = tbl[t].jalr;
            bus.imm = tbl[t].imm; bus.rs1 = tbl[t].rs1;
            cycle();
            chk64("tbl_addr", bus.imem_addr, tbl[t].exp_addr);
            chk1("tbl_trap", bus.misalign_trap, tbl[t].exp_trap);
            chk1("tbl_req", bus.imem_req, !tbl[t].exp_trap);
        end

        // trap is sticky until flush
        idle_inputs();
        do_reset();
        bus.flush = 1'b1; bus.flush_pc = 64'h100;
        cycle();
        bus.flush = 1'b0;
        cycle();
        bus.jalr_en = 1'b1; bus.rs1 = 64'h200; bus.imm = 64'h2;
        cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk1("trap_hold", bus.misalign_trap, 1'b1);
            chk1("trap_noreq", bus.imem_req, 1'b0);
        end
        bus.flush = 1'b1; bus.flush_pc = 64'h80;
        cycle();
        bus.flush = 1'b0;
        chk1("trap_cleared", bus.misalign_trap, 1'b0);
        chk64("trap_flush_addr", bus.imem_addr, 64'h80);
        chk1("trap_flush_req", bus.imem_req, 1'b1);

        // flush before ack: late data discarded
        idle_inputs();
        mem_auto = 1'b0; man_ack = 1'b0;
        do_reset();
        cycle();
        bus.flush = 1'b1; bus.flush_pc = 64'h40;
        cycle();
        bus.flush = 1'b0;
        cycle();
        cycle();
        chk1("drop_noreq", bus.imem_req, 1'b0);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        cycle();
        chk64("drop_addr", bus.imem_addr, 64'h40);
        chk1("drop_req", bus.imem_req, 1'b1);
        chk64("drop_discard", 64'(bus.instruction), 64'h0);
        man_rdata = memfn(64'h40);
        cycle();
        man_ack = 1'b0;
        chk64("drop_refetch", 64'(bus.instruction), 64'(memfn(64'h40)));

        // wrap-around, then reset mid-FETCH with a late ack
        idle_inputs();
        mem_auto = 1'b1; mem_lat = 1;
        do_reset();
        bus.flush = 1'b1; bus.flush_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        bus.flush = 1'b0;
        cycle();
        mem_auto = 1'b0; man_ack = 1'b0;
        cycle();
        chk64("wrap_addr", bus.imem_addr, 64'h0);
        chk1("wrap_req", bus.imem_req, 1'b1);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        do_reset();
        cycle();
        chk64("late_ack_ignored", 64'(bus.instruction), 64'h0);
        man_ack = 1'b0;
        cycle();

        // randomized run against the model
        idle_inputs();
        mem_auto = 1'b1; mem_lat = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.stall     = ($urandom_range(0, 9) < 3);
            bus.branch_en = 1'($urandom_range(0, 1));
            bus.jalr_en   = ($urandom_range(0, 3) == 0);
            bus.imm       = 64'($urandom_range(0, 511)) - 64'd256;
            if ($urandom_range(0, 7) != 0) bus.imm[1:0] = 2'b00;
            bus.rs1       = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) != 0) bus.rs1[1] = 1'b0;
            bus.flush     = ($urandom_range(0, 99) < 6);
            bus.flush_pc  = {$urandom(), $urandom()};
            if ($urandom_range(0, 9) != 0) bus.flush_pc[1:0] = 2'b00;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
